// File: rtl/branch_cmp_unit.sv
// Branch-condition unit: register/immediate compares, sticky flags and a
// saturating hardware loop counter, behind a one-entry valid/ready output slot.
module branch_cmp_unit #(
  parameter int WIDTH  = 16,
  parameter int LOOP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic              signed_mode,
  input  logic [WIDTH-1:0]  rddata,
  input  logic [WIDTH-1:0]  rsdata,
  input  logic [WIDTH-1:0]  n,
  input  logic              loop_load,
  input  logic [LOOP_W-1:0] loop_init,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              jump,
  output logic [2:0]        flags,
  output logic [LOOP_W-1:0] loop_count,
  output logic              loop_zero
);

  localparam logic [3:0] C_GT      = 4'b0000;
  localparam logic [3:0] C_LT      = 4'b0001;
  localparam logic [3:0] C_EQ      = 4'b0010;
  localparam logic [3:0] C_NE      = 4'b0011;
  localparam logic [3:0] C_ZERO    = 4'b0100;
  localparam logic [3:0] C_LOOP    = 4'b0101;
  localparam logic [3:0] C_FLAG_GT = 4'b0110;
  localparam logic [3:0] C_FLAG_EQ = 4'b0111;
  localparam logic [3:0] C_IGT     = 4'b1000;
  localparam logic [3:0] C_ILT     = 4'b1001;
  localparam logic [3:0] C_IEQ     = 4'b1010;
  localparam logic [3:0] C_INE     = 4'b1011;

  typedef enum logic {S_EMPTY, S_FULL} slot_t;

  slot_t               r_state_p1;
  slot_t               w_state_next;
  logic                r_jump_p1;
  logic [2:0]          r_flags_p1;
  logic [LOOP_W-1:0]   r_loop_count_p1;

  logic                w_accept_p0;
  logic [WIDTH-1:0]    w_b_raw_p0;
  logic signed [WIDTH:0] w_a_x_p0;
  logic signed [WIDTH:0] w_b_x_p0;
  logic [2:0]          w_cmp_p0;
  logic                w_cmp_code_p0;
  logic                w_is_loop_p0;
  logic [LOOP_W-1:0]   w_loop_base_p0;
  logic [LOOP_W-1:0]   w_loop_dec_p0;
  logic                w_jump_p0;

  // Decrement that sticks at zero instead of wrapping.
  function automatic logic [LOOP_W-1:0] sat_dec(input logic [LOOP_W-1:0] v);
    sat_dec = (v == '0) ? '0 : v - LOOP_W'(1);
  endfunction

  function automatic logic [2:0] cmp_flags(input logic signed [WIDTH:0] a,
                                           input logic signed [WIDTH:0] b);
    cmp_flags = {a > b, a < b, a == b};
  endfunction

  // ---- p0: request decode and compare ----
  assign in_ready    = (r_state_p1 == S_EMPTY) | out_ready;
  assign w_accept_p0 = in_valid & in_ready;

  always_comb begin
    w_b_raw_p0 = rsdata;
    if (cond == C_ZERO) w_b_raw_p0 = '0;
    else if (cond[3])   w_b_raw_p0 = n;
  end

  // One extra bit carries either the sign or a zero, so one signed compare covers both modes.
  assign w_a_x_p0 = {signed_mode & rddata[WIDTH-1], rddata};
  assign w_b_x_p0 = {signed_mode & w_b_raw_p0[WIDTH-1], w_b_raw_p0};
  assign w_cmp_p0 = cmp_flags(w_a_x_p0, w_b_x_p0);

  assign w_cmp_code_p0  = (cond <= C_ZERO) || (cond[3:2] == 2'b10);
  assign w_is_loop_p0   = (cond == C_LOOP);
  assign w_loop_base_p0 = loop_load ? loop_init : r_loop_count_p1;
  assign w_loop_dec_p0  = sat_dec(w_loop_base_p0);

  always_comb begin
    w_jump_p0 = 1'b0;
    case (cond)
      C_GT, C_IGT:         w_jump_p0 = w_cmp_p0[2];
      C_LT, C_ILT:         w_jump_p0 = w_cmp_p0[1];
      C_EQ, C_IEQ, C_ZERO: w_jump_p0 = w_cmp_p0[0];
      C_NE, C_INE:         w_jump_p0 = ~w_cmp_p0[0];
      C_LOOP:              w_jump_p0 = (w_loop_dec_p0 != '0);
      C_FLAG_GT:           w_jump_p0 = r_flags_p1[2];
      C_FLAG_EQ:           w_jump_p0 = r_flags_p1[0];
      default:             w_jump_p0 = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state_p1;
    case (r_state_p1)
      S_EMPTY: if (w_accept_p0) w_state_next = S_FULL;
      S_FULL:  if (out_ready && !w_accept_p0) w_state_next = S_EMPTY;
    endcase
  end

  // ---- p1: output slot, sticky flags, loop counter ----
  always_ff @(posedge clk) begin
    if (reset) r_state_p1 <= S_EMPTY;
    else       r_state_p1 <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_jump_p1       <= 1'b0;
      r_flags_p1      <= 3'b000;
      r_loop_count_p1 <= '0;
    end else begin
      if (w_accept_p0) r_jump_p1 <= w_jump_p0;
      if (w_accept_p0 && w_cmp_code_p0) r_flags_p1 <= w_cmp_p0;
      if (w_accept_p0 && w_is_loop_p0) r_loop_count_p1 <= w_loop_dec_p0;
      else if (loop_load)              r_loop_count_p1 <= loop_init;
    end
  end

  assign out_valid  = (r_state_p1 == S_FULL);
  assign jump       = r_jump_p1;
  assign flags      = r_flags_p1;
  assign loop_count = r_loop_count_p1;
  assign loop_zero  = (r_loop_count_p1 == '0);

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Bench for branch_cmp_unit: vector table plus loop, backpressure and reset sequences,
// with jump results checked through a queue scoreboard.
module tb_branch_cmp_unit;
  localparam int WIDTH  = 16;
  localparam int LOOP_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, in_valid, in_ready, signed_mode, loop_load;
  logic              out_valid, out_ready, jump, loop_zero;
  logic [3:0]        cond;
  logic [WIDTH-1:0]  rddata, rsdata, n;
  logic [LOOP_W-1:0] loop_init, loop_count;
  logic [2:0]        flags;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic sb_q[$];

  branch_cmp_unit #(.WIDTH(WIDTH), .LOOP_W(LOOP_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .signed_mode(signed_mode), .rddata(rddata), .rsdata(rsdata),
    .n(n), .loop_load(loop_load), .loop_init(loop_init), .out_valid(out_valid),
    .out_ready(out_ready), .jump(jump), .flags(flags), .loop_count(loop_count),
    .loop_zero(loop_zero)
  );

  typedef struct {
    logic [3:0]  c;
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic        j;
    logic [2:0]  f;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every transferred result is popped and compared against the queued expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got result jump=%0b, expected no result", jump);
      end else begin
        check("sb_jump", 32'(jump), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic sm, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] imm, input logic exp_j);
    int waited = 0;
    cond = c; signed_mode = sm; rddata = a; rsdata = b; n = imm; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, expected 1");
    end else begin
      sb_q.push_back(exp_j);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_counter(input logic [15:0] v);
    loop_init = v; loop_load = 1'b1;
    @(posedge clk); #1;
    loop_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_loop_j[3];
    exp_loop_j[0] = 1'b1; exp_loop_j[1] = 1'b1; exp_loop_j[2] = 1'b0;

    //          cond     sm    rddata    rsdata    n         jump  flags
    vt[0]  = '{4'b0000, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3'b010};
    vt[1]  = '{4'b0000, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3'b100};
    vt[2]  = '{4'b1010, 1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b1, 3'b001};
    vt[3]  = '{4'b0100, 1'b0, 16'h0000, 16'h0005, 16'h0007, 1'b1, 3'b001};
    vt[4]  = '{4'b0001, 1'b1, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 3'b010};
    vt[5]  = '{4'b0001, 1'b0, 16'h8000, 16'h7FFF, 16'h0000, 1'b0, 3'b100};
    vt[6]  = '{4'b0011, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b001};
    vt[7]  = '{4'b1011, 1'b0, 16'h0005, 16'h0005, 16'h0006, 1'b1, 3'b010};
    vt[8]  = '{4'b1000, 1'b1, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 3'b100};
    vt[9]  = '{4'b0110, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b100};
    vt[10] = '{4'b0111, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b100};
    vt[11] = '{4'b1100, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b100};
    vt[12] = '{4'b0100, 1'b1, 16'h8000, 16'h0000, 16'h0000, 1'b0, 3'b010};
    vt[13] = '{4'b0111, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b010};
    vt[14] = '{4'b0010, 1'b0, 16'h0007, 16'h0007, 16'h0000, 1'b1, 3'b001};
    vt[15] = '{4'b0111, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b001};
    vt[16] = '{4'b1001, 1'b0, 16'h0000, 16'h0001, 16'h0000, 1'b0, 3'b001};
    vt[17] = '{4'b0110, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b001};

    reset = 1'b1; in_valid = 1'b0; cond = 4'b0; signed_mode = 1'b0;
    rddata = '0; rsdata = '0; n = '0; loop_load = 1'b0; loop_init = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_jump", 32'(jump), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_loop_count", 32'(loop_count), 32'd0);
    check("rst_loop_zero", 32'(loop_zero), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      send(vt[i].c, vt[i].sm, vt[i].a, vt[i].b, vt[i].imm, vt[i].j);
      check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vt[i].f));
    end
    @(posedge clk); #1;

    load_counter(16'd3);
    check("load3_count", 32'(loop_count), 32'd3);
    check("load3_zero", 32'(loop_zero), 32'd0);
    for (int k = 0; k < 3; k++) begin
      send(4'b0101, 1'b0, 16'h0, 16'h0, 16'h0, exp_loop_j[k]);
      check($sformatf("loop%0d_count", k), 32'(loop_count), 32'(2 - k));
    end
    send(4'b0101, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    check("loop_sat_count", 32'(loop_count), 32'd0);
    check("loop_sat_zero", 32'(loop_zero), 32'd1);
    check("loop_flags_kept", 32'(flags), 32'b001);

    load_counter(16'd5);
    check("load5_count", 32'(loop_count), 32'd5);
    loop_init = 16'd1; loop_load = 1'b1;
    send(4'b0101, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    loop_load = 1'b0;
    check("collide1_count", 32'(loop_count), 32'd0);
    loop_init = 16'd4; loop_load = 1'b1;
    send(4'b0101, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    loop_load = 1'b0;
    check("collide4_count", 32'(loop_count), 32'd3);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(4'b0010, 1'b0, 16'h0001, 16'h0001, 16'h0, 1'b1);
    cond = 4'b0011; rddata = 16'h0001; rsdata = 16'h0001; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_jump", k), 32'(jump), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    sb_q.push_back(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drained_out_valid", 32'(out_valid), 32'd0);
    check("bp_drained_sb", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;

    load_counter(16'd7);
    out_ready = 1'b0;
    send(4'b0000, 1'b0, 16'h0005, 16'h0003, 16'h0, 1'b1);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_jump", 32'(jump), 32'd1);
    check("pre_rst_flags", 32'(flags), 32'b100);
    check("pre_rst_count", 32'(loop_count), 32'd7);
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; cond = 4'b0101;
    loop_load = 1'b1; loop_init = 16'd9;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; loop_load = 1'b0; out_ready = 1'b0;
    sb_q.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_jump", 32'(jump), 32'd0);
    check("mid_rst_flags", 32'(flags), 32'd0);
    check("mid_rst_count", 32'(loop_count), 32'd0);
    check("mid_rst_zero", 32'(loop_zero), 32'd1);

    out_ready = 1'b1;
    send(4'b0010, 1'b0, 16'h0002, 16'h0002, 16'h0, 1'b1);
    check("post_rst_flags", 32'(flags), 32'b001);
    repeat (2) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
